prepare_ok_tx: RTL and testbench

PREPARE_OK_TX -- requirements
Module: vr_ctrl_msg_tx

---
 rtl/prepare_ok_tx.sv | 166 ++++++++++++++++
 tb/tb_prepare_ok_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prepare_ok_tx.sv
// Serialises one latched control command into a metadata word plus a two-beat,
// MSB-first stream message (13-byte beehive header followed by the type's body).
module prepare_ok_tx #(
    parameter int DATA_W = 256,
    parameter int PAD_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_val,
    output logic              cmd_rdy,
    input  logic [7:0]        cmd_type,
    input  logic [47:0]       cmd_dst,
    input  logic [63:0]       cmd_f0,
    input  logic [63:0]       cmd_f1,
    input  logic [63:0]       cmd_f2,
    input  logic [63:0]       cmd_f3,
    input  logic [7:0]        cmd_bool,
    output logic              meta_val,
    input  logic              meta_rdy,
    output logic [47:0]       meta_dst,
    output logic [15:0]       meta_len,
    output logic              data_val,
    input  logic              data_rdy,
    output logic [DATA_W-1:0] data,
    output logic              data_last,
    output logic [PAD_W-1:0]  data_padbytes,
    output logic              err_bad_type
);

    localparam logic [7:0]  T_PREP_OK  = 8'd6;
    localparam logic [7:0]  T_SVC      = 8'd10;
    localparam logic [7:0]  T_VRR      = 8'd14;
    localparam logic [31:0] FRAG_NUM   = 32'h18030520;
    localparam logic [15:0] HDR_BYTES  = 16'd13;

    typedef enum logic [1:0] {IDLE, META, DATA0, DATA1} state_e;

    state_e               r_state;
    state_e               w_state_next;

    logic                 r_alive;
    logic                 r_err;
    logic [7:0]           r_type;
    logic [47:0]          r_dst;
    logic [63:0]          r_f0;
    logic [63:0]          r_f1;
    logic [63:0]          r_f2;
    logic [63:0]          r_f3;
    logic [7:0]           r_bool;
    logic [7:0]           r_body_len;
    logic [15:0]          r_len;
    logic [PAD_W-1:0]     r_pad;

    logic                 w_type_ok;
    logic [7:0]           w_body_len;
    logic                 w_idle_rdy;
    logic                 w_cmd_hs;
    logic [255:0]         w_body;
    logic [2*DATA_W-1:0]  w_stream;

    // Body size of the incoming command decides whether it is accepted at all.
    always_comb begin
        w_type_ok  = 1'b1;
        w_body_len = 8'd0;
        case (cmd_type)
            T_PREP_OK: w_body_len = 8'd32;
            T_SVC:     w_body_len = 8'd24;
            T_VRR:     w_body_len = 8'd25;
            default:   w_type_ok  = 1'b0;
        endcase
    end

    assign w_idle_rdy = r_alive && (r_state == IDLE);
    assign w_cmd_hs   = cmd_val && w_idle_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive    <= 1'b0;
            r_err      <= 1'b0;
            r_type     <= 8'd0;
            r_dst      <= 48'd0;
            r_f0       <= 64'd0;
            r_f1       <= 64'd0;
            r_f2       <= 64'd0;
            r_f3       <= 64'd0;
            r_bool     <= 8'd0;
            r_body_len <= 8'd0;
            r_len      <= 16'd0;
            r_pad      <= '0;
        end else begin
            r_alive <= 1'b1;
            r_err   <= w_cmd_hs && !w_type_ok;
            if (w_cmd_hs && w_type_ok) begin
                r_type     <= cmd_type;
                r_dst      <= cmd_dst;
                r_f0       <= cmd_f0;
                r_f1       <= cmd_f1;
                r_f2       <= cmd_f2;
                r_f3       <= cmd_f3;
                r_bool     <= cmd_bool;
                r_body_len <= w_body_len;
                r_len      <= HDR_BYTES + {8'd0, w_body_len};
                // Two beats hold 64 bytes; the header's 13 leave 51 for the body.
                r_pad      <= PAD_W'(8'd51 - w_body_len);
            end
        end
    end

    // Body left-aligned in 32 bytes so the unused tail is already zero.
    always_comb begin
        w_body = '0;
        case (r_type)
            T_PREP_OK: w_body = {r_f0, r_f1, r_f2, r_f3};
            T_SVC:     w_body = {r_f0, r_f1, r_f2, 64'd0};
            T_VRR:     w_body = {r_bool, r_f0, r_f1, r_f2, 56'd0};
            default:   w_body = '0;
        endcase
    end

    assign w_stream = {FRAG_NUM, r_type, 56'd0, r_body_len, w_body, 152'd0};

    always_comb begin
        w_state_next  = r_state;
        meta_val      = 1'b0;
        data_val      = 1'b0;
        data          = '0;
        data_last     = 1'b0;
        data_padbytes = '0;
        case (r_state)
            IDLE: begin
                if (w_cmd_hs && w_type_ok) w_state_next = META;
            end
            META: begin
                meta_val = 1'b1;
                if (meta_rdy) w_state_next = DATA0;
            end
            DATA0: begin
                data_val = 1'b1;
                data     = w_stream[2*DATA_W-1:DATA_W];
                if (data_rdy) w_state_next = DATA1;
            end
            DATA1: begin
                data_val      = 1'b1;
                data          = w_stream[DATA_W-1:0];
                data_last     = 1'b1;
                data_padbytes = r_pad;
                if (data_rdy) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign cmd_rdy      = w_idle_rdy;
    assign meta_dst     = r_dst;
    assign meta_len     = r_len;
    assign err_bad_type = r_err;

endmodule

// File: tb/tb_prepare_ok_tx.sv
// Randomised and directed checks of prepare_ok_tx against a byte-level message model.
module tb_prepare_ok_tx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_val = 1'b0;
    logic         cmd_rdy;
    logic [7:0]   cmd_type = 8'd0;
    logic [47:0]  cmd_dst = 48'd0;
    logic [63:0]  cmd_f0 = 64'd0;
    logic [63:0]  cmd_f1 = 64'd0;
    logic [63:0]  cmd_f2 = 64'd0;
    logic [63:0]  cmd_f3 = 64'd0;
    logic [7:0]   cmd_bool = 8'd0;
    logic         meta_val;
    logic         meta_rdy = 1'b0;
    logic [47:0]  meta_dst;
    logic [15:0]  meta_len;
    logic         data_val;
    logic         data_rdy = 1'b0;
    logic [255:0] data;
    logic         data_last;
    logic [4:0]   data_padbytes;
    logic         err_bad_type;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]   m_body[$];
    logic [7:0]   m_msg[$];
    logic [255:0] obs_b0;
    logic [255:0] obs_b1;
    logic [15:0]  obs_len;
    logic [4:0]   obs_pad;

    prepare_ok_tx dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_type(cmd_type), .cmd_dst(cmd_dst),
        .cmd_f0(cmd_f0), .cmd_f1(cmd_f1), .cmd_f2(cmd_f2), .cmd_f3(cmd_f3), .cmd_bool(cmd_bool),
        .meta_val(meta_val), .meta_rdy(meta_rdy), .meta_dst(meta_dst), .meta_len(meta_len),
        .data_val(data_val), .data_rdy(data_rdy), .data(data), .data_last(data_last),
        .data_padbytes(data_padbytes), .err_bad_type(err_bad_type)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic body_push(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) m_body.push_back(v[8*i +: 8]);
    endtask

    task automatic msg_push(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) m_msg.push_back(v[8*i +: 8]);
    endtask

    // Builds the byte stream of a message; elen = 0 marks an unsupported type.
    task automatic model(input logic [7:0] t, input logic [63:0] f0, input logic [63:0] f1,
                         input logic [63:0] f2, input logic [63:0] f3, input logic [7:0] bl,
                         output logic [255:0] e0, output logic [255:0] e1,
                         output int elen, output int epad);
        m_body.delete();
        m_msg.delete();
        case (t)
            8'd6:  begin body_push(f0, 8); body_push(f1, 8); body_push(f2, 8); body_push(f3, 8); end
            8'd10: begin body_push(f0, 8); body_push(f1, 8); body_push(f2, 8); end
            8'd14: begin body_push(64'(bl), 1); body_push(f0, 8); body_push(f1, 8); body_push(f2, 8); end
            default: ;
        endcase
        e0 = '0;
        e1 = '0;
        elen = 0;
        epad = 0;
        if (m_body.size() != 0) begin
            msg_push(64'h18030520, 4);
            msg_push(64'(t), 1);
            msg_push(64'(m_body.size()), 8);
            foreach (m_body[i]) m_msg.push_back(m_body[i]);
            elen = m_msg.size();
            epad = 64 - elen;
            for (int i = 0; i < elen; i++) begin
                if (i < 32) e0[255 - 8*i -: 8] = m_msg[i];
                else        e1[255 - 8*(i-32) -: 8] = m_msg[i];
            end
        end
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic run_msg(input logic [7:0] t, input logic [47:0] dst, input logic [63:0] f0,
                           input logic [63:0] f1, input logic [63:0] f2, input logic [63:0] f3,
                           input logic [7:0] bl, input int md, input int d0, input int d1);
        logic [255:0] e0, e1, eb;
        int elen, epad, wn, dly;
        model(t, f0, f1, f2, f3, bl, e0, e1, elen, epad);
        wn = 0;
        while (!cmd_rdy && wn < 20) begin
            @(negedge clk);
            wn++;
        end
        chk("cmd_rdy_idle", 256'(cmd_rdy), 256'(1));
        cmd_type = t; cmd_dst = dst; cmd_f0 = f0; cmd_f1 = f1; cmd_f2 = f2; cmd_f3 = f3;
        cmd_bool = bl; cmd_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_val = 1'b0;
        cmd_type = 8'($urandom); cmd_dst = {$urandom, 16'($urandom)};
        cmd_f0 = {$urandom, $urandom}; cmd_f1 = {$urandom, $urandom};
        cmd_f2 = {$urandom, $urandom}; cmd_f3 = {$urandom, $urandom}; cmd_bool = 8'($urandom);
        if (elen == 0) begin
            chk("err_pulse", 256'(err_bad_type), 256'(1));
            chk("err_no_meta", 256'(meta_val), 256'(0));
            chk("err_no_data", 256'(data_val), 256'(0));
            chk("err_cmd_rdy", 256'(cmd_rdy), 256'(1));
            @(negedge clk);
            chk("err_one_cycle", 256'(err_bad_type), 256'(0));
            chk("err_no_meta2", 256'(meta_val), 256'(0));
            chk("err_no_data2", 256'(data_val), 256'(0));
            $display("txn type=%0d rejected", t);
            return;
        end
        for (int k = 0; k <= md; k++) begin
            chk("meta_val", 256'(meta_val), 256'(1));
            chk("meta_no_data", 256'(data_val), 256'(0));
            chk("meta_cmd_rdy", 256'(cmd_rdy), 256'(0));
            chk("meta_no_err", 256'(err_bad_type), 256'(0));
            chk("meta_dst", 256'(meta_dst), 256'(dst));
            chk("meta_len", 256'(meta_len), 256'(elen));
            obs_len = meta_len;
            meta_rdy = (k == md);
            @(posedge clk);
            @(negedge clk);
        end
        meta_rdy = 1'b0;
        for (int b = 0; b < 2; b++) begin
            dly = (b == 0) ? d0 : d1;
            eb  = (b == 0) ? e0 : e1;
            for (int k = 0; k <= dly; k++) begin
                chk("data_val", 256'(data_val), 256'(1));
                chk("data_no_meta", 256'(meta_val), 256'(0));
                chk("data_cmd_rdy", 256'(cmd_rdy), 256'(0));
                chk("data_beat", data, eb);
                chk("data_last", 256'(data_last), 256'(b));
                chk("data_pad", 256'(data_padbytes), 256'((b == 0) ? 0 : epad));
                if (b == 0) obs_b0 = data;
                else begin
                    obs_b1 = data;
                    obs_pad = data_padbytes;
                end
                data_rdy = (k == dly);
                @(posedge clk);
                @(negedge clk);
            end
            data_rdy = 1'b0;
        end
        chk("done_cmd_rdy", 256'(cmd_rdy), 256'(1));
        chk("done_no_data", 256'(data_val), 256'(0));
        chk("done_no_meta", 256'(meta_val), 256'(0));
        $display("txn type=%0d len=%0d pad=%0d meta_wait=%0d beat_waits=%0d/%0d", t, elen, epad, md, d0, d1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_rdy"}, 256'(cmd_rdy), 256'(0));
        chk({tag, "_meta_val"}, 256'(meta_val), 256'(0));
        chk({tag, "_data_val"}, 256'(data_val), 256'(0));
        chk({tag, "_data_last"}, 256'(data_last), 256'(0));
        chk({tag, "_err"}, 256'(err_bad_type), 256'(0));
        chk({tag, "_data"}, data, 256'(0));
        chk({tag, "_meta_len"}, 256'(meta_len), 256'(0));
        chk({tag, "_meta_dst"}, 256'(meta_dst), 256'(0));
        chk({tag, "_pad"}, 256'(data_padbytes), 256'(0));
    endtask

    initial begin
        logic [7:0] t;
        #1;
        chk_reset_outputs("rst0");
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst1");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_rdy", 256'(cmd_rdy), 256'(1));

        run_msg(8'd6, {32'h0A000001, 16'h3039}, 64'd1, 64'h10, 64'd2, 64'hF, 8'd0, 0, 0, 0);
        chk("prep_len", 256'(obs_len), 256'(45));
        chk("prep_hdr", 256'(obs_b0[255 -: 104]), 256'(104'h18030520_06_0000000000000020));
        chk("prep_pad", 256'(obs_pad), 256'(19));

        run_msg(8'd10, 48'h0102_0304_0506, 64'd3, 64'd1, 64'd7, 64'hDEAD, 8'd0, 0, 0, 0);
        chk("svc_len", 256'(obs_len), 256'(37));
        chk("svc_msg_len", 256'(obs_b0[215 -: 64]), 256'(24));
        chk("svc_view", 256'(obs_b0[151 -: 64]), 256'(3));
        chk("svc_pad", 256'(obs_pad), 256'(27));

        run_msg(8'd14, 48'h0A0B_0C0D_0E0F, 64'hAA, 64'hBB, 64'd0, 64'h55, 8'd1, 0, 0, 0);
        chk("vrr_len", 256'(obs_len), 256'(38));
        chk("vrr_bool", 256'(obs_b0[151:144]), 256'(1));
        chk("vrr_pad", 256'(obs_pad), 256'(26));
        chk("vrr_tail_zero", 256'(obs_b1[207:0]), 256'(0));

        run_msg(8'd5, 48'd1, 64'd1, 64'd2, 64'd3, 64'd4, 8'd1, 0, 0, 0);

        run_msg(8'd6, 48'hABCD_0000_1234, 64'h11, 64'h22, 64'h33, 64'h44, 8'd0, 5, 1, 2);

        // Reset while beat 0 is waiting for acceptance.
        cmd_type = 8'd6; cmd_dst = 48'h1; cmd_f0 = 64'h9; cmd_f1 = 64'h8; cmd_f2 = 64'h7;
        cmd_f3 = 64'h6; cmd_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_val = 1'b0;
        meta_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        meta_rdy = 1'b0;
        chk("pre_rst_data0", 256'(data_val), 256'(1));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rdy", 256'(cmd_rdy), 256'(1));
        chk("midrst_no_data", 256'(data_val), 256'(0));
        run_msg(8'd10, 48'h5555_6666_7777, 64'h123, 64'h456, 64'h789, 64'h0, 8'd0, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0: begin
                    t = 8'($urandom);
                    if (t == 8'd6 || t == 8'd10 || t == 8'd14) t = 8'd5;
                end
                1, 2, 3: t = 8'd6;
                4, 5, 6: t = 8'd10;
                default: t = 8'd14;
            endcase
            run_msg(t, {$urandom, 16'($urandom)}, {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
